mem_arbiter: RTL and testbench

Shares the single CPU-side memory port of the external-bus interface among N requesters (instruction fetch, data access, DMA). It picks one requester by round-robin, latches that requester's command into registered `memory_*` outputs, and holds them until the bus interface pulses `memory_done`. It then routes the completion back to the owning requester. An optional lock lets one requester keep the bus across several transactions, for example a read-modify-write.

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter, grouped into one bundle.
// The master view belongs to the arbiter; the slave view belongs to the requesters and the bus interface.
interface mem_arbiter_if #(
    parameter int unsigned N = 3
);
    logic [N-1:0]    req_read;
    logic [N-1:0]    req_write;
    logic [16*N-1:0] req_addr;
    logic [8*N-1:0]  req_wdata;
    logic [N-1:0]    req_lock;
    logic [N-1:0]    req_done;
    logic [7:0]      req_rdata;

    logic            memory_read;
    logic            memory_write;
    logic [15:0]     memory_addr;
    logic [7:0]      memory_wdata;
    logic [7:0]      memory_rdata;
    logic            memory_done;

    modport master (
        input  req_read, req_write, req_addr, req_wdata, req_lock,
        output req_done, req_rdata,
        output memory_read, memory_write, memory_addr, memory_wdata,
        input  memory_rdata, memory_done
    );

    modport slave (
        output req_read, req_write, req_addr, req_wdata, req_lock,
        input  req_done, req_rdata,
        input  memory_read, memory_write, memory_addr, memory_wdata,
        output memory_rdata, memory_done
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one registered memory command port among N requesters,
// with an optional per-owner lock that is force-released after LOCK_TIMEOUT idle cycles.
module mem_arbiter #(
    parameter int unsigned N            = 3,
    parameter int unsigned LOCK_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus
);
    localparam int unsigned OW = (N > 2) ? 2 : 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [OW-1:0]  owner;
    logic [OW-1:0]  last;
    logic           locked;
    logic [7:0]     lock_cnt;

    logic           cmd_read;
    logic           cmd_write;
    logic [15:0]    cmd_addr;
    logic [7:0]     cmd_wdata;

    logic [N-1:0]   active;
    logic           grant_valid;
    logic [OW-1:0]  grant_idx;
    logic [OW-1:0]  cand_idx;
    logic [15:0]    sel_addr;
    logic [7:0]     sel_wdata;
    logic           sel_write;
    logic           lock_expire;

    assign active = bus.req_read | bus.req_write;

    // Search starts one past the last unlocked grant; a held lock narrows the field to the owner.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        if (locked) begin
            grant_valid = active[owner];
            grant_idx   = owner;
        end else begin
            for (int unsigned k = 1; k <= N; k++) begin
                cand_idx = OW'((32'(last) + k) % N);
                if (!grant_valid && active[cand_idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand_idx;
                end
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_idx == OW'(i)) begin
                sel_addr  = bus.req_addr[16*i +: 16];
                sel_wdata = bus.req_wdata[8*i +: 8];
                sel_write = bus.req_write[i];
            end
        end
    end

    assign lock_expire = (lock_cnt + 8'd1) == 8'(LOCK_TIMEOUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = BUSY;
            BUSY:    if (bus.memory_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= '0;
            last      <= OW'(N - 1);
            locked    <= 1'b0;
            lock_cnt  <= '0;
            cmd_read  <= 1'b0;
            cmd_write <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner     <= grant_idx;
                        lock_cnt  <= '0;
                        cmd_addr  <= sel_addr;
                        cmd_wdata <= sel_wdata;
                        cmd_write <= sel_write;
                        cmd_read  <= !sel_write;
                        if (!locked) begin
                            last <= grant_idx;
                        end
                    end else if (locked) begin
                        // Owner is idle while holding the lock: count towards forced release.
                        if (lock_expire) begin
                            locked   <= 1'b0;
                            lock_cnt <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + 8'd1;
                        end
                    end
                end
                BUSY: begin
                    if (bus.memory_done) begin
                        cmd_read  <= 1'b0;
                        cmd_write <= 1'b0;
                        locked    <= bus.req_lock[owner];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.memory_read  = cmd_read;
    assign bus.memory_write = cmd_write;
    assign bus.memory_addr  = cmd_addr;
    assign bus.memory_wdata = cmd_wdata;

    assign bus.req_done  = (state == BUSY && bus.memory_done) ? (N'(1) << owner) : '0;
    assign bus.req_rdata = bus.memory_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed multi-cycle sequences, and a randomized
// run checked against a transaction-level round-robin/lock-window model.
module tb_mem_arbiter;
    localparam int unsigned N  = 3;
    localparam int unsigned LT = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if #(.N(N)) bus ();

    mem_arbiter #(.N(N), .LOCK_TIMEOUT(LT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        bus.req_read     = '0;
        bus.req_write    = '0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.req_lock     = '0;
        bus.memory_done  = 1'b0;
        bus.memory_rdata = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_cmd(input int max, output int n);
        n = 0;
        while (!(bus.memory_read || bus.memory_write) && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic serve(input logic [7:0] rd, output logic [2:0] done_vec, output logic [7:0] rdata);
        bus.memory_done  = 1'b1;
        bus.memory_rdata = rd;
        #1;
        done_vec = bus.req_done;
        rdata    = bus.req_rdata;
        tick();
        bus.memory_done = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  rd;
        logic [2:0]  wr;
        logic [47:0] addr;
        logic [23:0] wdata;
        logic [7:0]  bus_rdata;
        int          exp_owner;
        logic        exp_read;
        logic        exp_write;
        logic [15:0] exp_addr;
        logic [7:0]  exp_wdata;
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [2:0]  dv;
        logic [7:0]  rv;
        int          n;
        // random-phase requester and model state
        bit          pend[3];
        logic        p_rd[3];
        logic        p_wr[3];
        logic        p_lock[3];
        logic [15:0] p_addr[3];
        logic [7:0]  p_wdata[3];
        bit          m_busy;
        int          m_owner;
        int          m_last;
        int          excl_owner;
        int          excl_until;
        logic        e_rd;
        logic        e_wr;
        logic [15:0] e_addr;
        logic [7:0]  e_wdata;
        bit          comp_valid;
        int          comp_owner;
        bit          done;
        logic [7:0]  rdat;
        bit          found;
        bit          locked_now;
        int          g;

        vecs[0] = '{3'b010, 3'b000, {16'h0000, 16'h1234, 16'h0000}, 24'h000000, 8'h5A, 1, 1'b1, 1'b0, 16'h1234, 8'h00};
        vecs[1] = '{3'b100, 3'b100, {16'h00FF, 16'h0000, 16'h0000}, 24'hC30000, 8'h00, 2, 1'b0, 1'b1, 16'h00FF, 8'hC3};
        vecs[2] = '{3'b111, 3'b000, {16'h3333, 16'h2222, 16'h1111}, 24'h030201, 8'hA5, 0, 1'b1, 1'b0, 16'h1111, 8'h01};
        vecs[3] = '{3'b110, 3'b000, {16'h3333, 16'h2222, 16'h1111}, 24'h030201, 8'h3C, 1, 1'b1, 1'b0, 16'h2222, 8'h02};
        vecs[4] = '{3'b000, 3'b001, {16'h3333, 16'h2222, 16'hBEEF}, 24'h030277, 8'hFF, 0, 1'b0, 1'b1, 16'hBEEF, 8'h77};
        vecs[5] = '{3'b100, 3'b010, {16'h3333, 16'h2222, 16'h1111}, 24'h030201, 8'h81, 1, 1'b0, 1'b1, 16'h2222, 8'h02};

        // Reset state and a memory_done that arrives while idle
        reset_dut();
        check("rst_read",  bus.memory_read,  0);
        check("rst_write", bus.memory_write, 0);
        check("rst_addr",  bus.memory_addr,  0);
        check("rst_wdata", bus.memory_wdata, 0);
        bus.memory_done = 1'b1;
        #1;
        check("idle_done_ignored", bus.req_done, 0);
        tick();
        bus.memory_done = 1'b0;
        check("idle_done_no_cmd", {bus.memory_read, bus.memory_write}, 0);

        // Table vectors, each from reset so requester 0 has first priority
        for (int v = 0; v < 6; v++) begin
            reset_dut();
            bus.req_read  = vecs[v].rd;
            bus.req_write = vecs[v].wr;
            bus.req_addr  = vecs[v].addr;
            bus.req_wdata = vecs[v].wdata;
            tick();
            check($sformatf("v%0d_read", v),  bus.memory_read,  vecs[v].exp_read);
            check($sformatf("v%0d_write", v), bus.memory_write, vecs[v].exp_write);
            check($sformatf("v%0d_addr", v),  bus.memory_addr,  vecs[v].exp_addr);
            check($sformatf("v%0d_wdata", v), bus.memory_wdata, vecs[v].exp_wdata);
            serve(vecs[v].bus_rdata, dv, rv);
            check($sformatf("v%0d_done", v),  dv, 3'b001 << vecs[v].exp_owner);
            check($sformatf("v%0d_rdata", v), rv, vecs[v].bus_rdata);
            bus.req_read  = '0;
            bus.req_write = '0;
            check($sformatf("v%0d_drop", v), {bus.memory_read, bus.memory_write}, 0);
        end

        // Round-robin with all requesters continuously reading
        reset_dut();
        bus.req_read = 3'b111;
        bus.req_addr = {16'h0200, 16'h0100, 16'h0000};
        wait_cmd(20, n);
        for (int t = 0; t < 6; t++) begin
            check($sformatf("rr%0d_cmd", t),   bus.memory_read, 1);
            check($sformatf("rr%0d_owner", t), bus.memory_addr, 16'h0100 * (t % 3));
            serve(8'(t), dv, rv);
            check($sformatf("rr%0d_done", t), dv, 3'b001 << (t % 3));
            wait_cmd(20, n);
            if (t < 5) check($sformatf("rr%0d_gap", t), n + 1, 2);
        end

        // Lock: locked read then unlocked write by requester 0, requester 1 pending throughout
        reset_dut();
        bus.req_read  = 3'b011;
        bus.req_lock  = 3'b001;
        bus.req_addr  = {16'h0000, 16'hBBBB, 16'hAAAA};
        wait_cmd(20, n);
        check("lock_first_addr", bus.memory_addr, 16'hAAAA);
        serve(8'h11, dv, rv);
        check("lock_first_done", dv, 3'b001);
        bus.req_read  = 3'b010;
        bus.req_write = 3'b001;
        bus.req_lock  = 3'b000;
        bus.req_addr  = {16'h0000, 16'hBBBB, 16'hCCCC};
        bus.req_wdata = 24'h00003C;
        wait_cmd(20, n);
        check("lock_second_write", bus.memory_write, 1);
        check("lock_second_addr",  bus.memory_addr,  16'hCCCC);
        check("lock_second_wdata", bus.memory_wdata, 8'h3C);
        serve(8'h22, dv, rv);
        check("lock_second_done", dv, 3'b001);
        bus.req_write = 3'b000;
        wait_cmd(20, n);
        check("lock_then_req1", bus.memory_addr, 16'hBBBB);
        serve(8'h33, dv, rv);
        check("lock_req1_done", dv, 3'b010);
        bus.req_read = '0;

        // Lock timeout: owner goes idle, requester 1 waits out the window
        reset_dut();
        bus.req_read = 3'b011;
        bus.req_lock = 3'b001;
        bus.req_addr = {16'h0000, 16'h2222, 16'h1111};
        wait_cmd(20, n);
        check("lt_first_addr", bus.memory_addr, 16'h1111);
        serve(8'h44, dv, rv);
        check("lt_first_done", dv, 3'b001);
        bus.req_read = 3'b010;
        bus.req_lock = 3'b000;
        wait_cmd(LT + 40, n);
        check("lt_grant_latency", n, LT + 1);
        check("lt_grant_addr", bus.memory_addr, 16'h2222);
        serve(8'h55, dv, rv);
        bus.req_read = '0;

        // Asynchronous reset while a transaction is outstanding
        reset_dut();
        bus.req_read  = 3'b010;
        bus.req_addr  = {16'h0000, 16'h4444, 16'h5555};
        bus.req_wdata = 24'h009900;
        wait_cmd(20, n);
        check("mid_rst_pre_addr", bus.memory_addr, 16'h4444);
        bus.memory_done = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_read",  bus.memory_read,  0);
        check("mid_rst_write", bus.memory_write, 0);
        check("mid_rst_addr",  bus.memory_addr,  0);
        check("mid_rst_wdata", bus.memory_wdata, 0);
        check("mid_rst_done",  bus.req_done,     0);
        bus.memory_done = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.req_read = 3'b011;
        wait_cmd(20, n);
        check("mid_rst_req0_first", bus.memory_addr, 16'h5555);
        serve(8'h66, dv, rv);
        bus.req_read = '0;

        // Randomized traffic against the transaction-level model
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            pend[i] = 0; p_rd[i] = 0; p_wr[i] = 0; p_lock[i] = 0; p_addr[i] = '0; p_wdata[i] = '0;
        end
        m_busy = 0; m_owner = 0; m_last = 2; excl_owner = 0; excl_until = -1;
        e_rd = 0; e_wr = 0; e_addr = '0; e_wdata = '0;
        comp_valid = 0; comp_owner = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (comp_valid && comp_owner == i) pend[i] = 0;
                if (!pend[i] && $urandom_range(3) == 0) begin
                    pend[i]    = 1;
                    p_wr[i]    = 1'($urandom_range(1));
                    p_rd[i]    = p_wr[i] ? 1'($urandom_range(1)) : 1'b1;
                    p_lock[i]  = ($urandom_range(3) == 0);
                    p_addr[i]  = 16'($urandom);
                    p_wdata[i] = 8'($urandom);
                end
                bus.req_read[i]           = pend[i] & p_rd[i];
                bus.req_write[i]          = pend[i] & p_wr[i];
                bus.req_lock[i]           = pend[i] & p_lock[i];
                bus.req_addr[16*i +: 16]  = p_addr[i];
                bus.req_wdata[8*i +: 8]   = p_wdata[i];
            end
            done = m_busy ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
            rdat = 8'($urandom);
            bus.memory_done  = done;
            bus.memory_rdata = rdat;
            #1;
            check("rnd_read",  bus.memory_read,  e_rd);
            check("rnd_write", bus.memory_write, e_wr);
            if (e_rd || e_wr) begin
                check("rnd_addr",  bus.memory_addr,  e_addr);
                check("rnd_wdata", bus.memory_wdata, e_wdata);
            end
            check("rnd_done", bus.req_done, (m_busy && done) ? (3'b001 << m_owner) : 3'b000);
            if (m_busy && done) check("rnd_rdata", bus.req_rdata, rdat);

            comp_valid = 0;
            if (m_busy) begin
                if (done) begin
                    e_rd = 0; e_wr = 0; m_busy = 0;
                    comp_valid = 1; comp_owner = m_owner;
                    // A locked completion reserves the next LT cycles for the same owner.
                    if (p_lock[m_owner]) begin
                        excl_owner = m_owner;
                        excl_until = c + int'(LT);
                    end else begin
                        excl_until = -1;
                    end
                end
            end else begin
                found = 0; g = 0;
                locked_now = (c <= excl_until);
                if (locked_now) begin
                    if (pend[excl_owner]) begin found = 1; g = excl_owner; end
                end else begin
                    for (int k = 1; k <= 3; k++) begin
                        if (!found && pend[(m_last + k) % 3]) begin
                            found = 1; g = (m_last + k) % 3;
                        end
                    end
                end
                if (found) begin
                    if (!locked_now) m_last = g;
                    excl_until = -1;
                    m_busy  = 1;
                    m_owner = g;
                    e_wr    = p_wr[g];
                    e_rd    = !p_wr[g];
                    e_addr  = p_addr[g];
                    e_wdata = p_wdata[g];
                end
            end
            tick();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
